// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver with a double-buffered display value.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module ssd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  // load is a one-cycle strobe with no ready: capture is unconditional.
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;
  logic                    tick, wrap;
  logic [3:0]              nib;
  logic [6:0]              glyph_vis;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h7E;  4'h1: glyph = 7'h30;  4'h2: glyph = 7'h6D;  4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;  4'h5: glyph = 7'h5B;  4'h6: glyph = 7'h5F;  4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h7B;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;  4'hD: glyph = 7'h3D;  4'hE: glyph = 7'h4F;  default: glyph = 7'h01;
    endcase
  endfunction

  assign nib = act_dig_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  seen_nz;
  // Scan from the top digit down; everything above the first non-zero nibble blanks.
  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen_nz  = seen_nz | (act_dig_q[4*i +: 4] != 4'h0);
      blank[i] = ~seen_nz;
    end
  end
  assign glyph_vis = blank[idx_q] ? 7'h00 : glyph(nib);
`else
  assign glyph_vis = glyph(nib);
`endif

  always_comb begin
    tick       = enable && (cnt_q == CNT_MAX);
    wrap       = tick && (idx_q == IDX_MAX);
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    seg_d      = 7'h00;
    dp_d       = 1'b0;
    an_d       = '0;
    frame_d    = wrap;

    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
    end

    // While disabled there is no frame boundary to wait for, so loads go straight to active.
    if (load && (wrap || !enable)) begin
      act_dig_d = digits_in;
      act_dp_d  = dp_in;
    end else if (wrap) begin
      act_dig_d = pend_dig_q;
      act_dp_d  = pend_dp_q;
    end

    if (enable) begin
      seg_d = glyph_vis;
      dp_d  = act_dp_q[idx_q];
      an_d  = NUM_DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      an_q       <= '0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver (NUM_DIGITS=4, CLK_DIV=4); expectations are hand-set
// per frame from a glyph table, with the blanking rule applied when LEADING_ZERO_BLANK_EN is defined.
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int k      = 0;
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];

  ssd_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .digits_in(digits_in), .dp_in(dp_in),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] tb_glyph(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h01};
    return tbl[v];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [15:0] v, input logic [3:0] d);
    logic seen;
    for (int i = 0; i < 4; i++) begin
      exp_seg[i] = tb_glyph(v[i*4 +: 4]);
      exp_dp[i]  = d[i];
    end
`ifdef LEADING_ZERO_BLANK_EN
    seen = 1'b0;
    for (int i = 3; i > 0; i--) begin
      seen = seen | (v[i*4 +: 4] != 4'h0);
      if (!seen) exp_seg[i] = 7'h00;
    end
`else
    seen = 1'b0;
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_seg"}, 32'(seg_out), 32'h0);
    chk({tag, "_dp"},  32'(dp_out), 32'h0);
    chk({tag, "_an"},  32'(an_out), 32'h0);
    chk({tag, "_fd"},  32'(frame_done), 32'h0);
  endtask

  // k counts clock edges since the scan started at digit 0 with the prescaler at 0.
  task automatic step();
    int slot;
    @(posedge clk);
    #1;
    k++;
    slot = ((k - 1) / 4) % 4;
    chk("an",  32'(an_out), 32'(4'b0001 << slot));
    chk("seg", 32'(seg_out), 32'(exp_seg[slot]));
    chk("dp",  32'(dp_out), 32'(exp_dp[slot]));
    chk("fd",  32'(frame_done), 32'(((k - 1) % 16) == 15));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_load(input logic [15:0] v, input logic [3:0] d);
    digits_in = v;
    dp_in     = d;
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  task automatic step_off(input string tag);
    @(posedge clk);
    #1;
    chk_zero(tag);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
    #3;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_off("idle");
    step_off("idle");

    // Free-running scan of the reset value.
    enable = 1'b1;
    k = 0;
    set_exp(16'h0000, 4'b0000);
    steps(32);

    // Mid-frame load held off until the wrap.
    steps(5);
    step_load(16'h1F3A, 4'b0100);
    steps(10);
    set_exp(16'h1F3A, 4'b0100);
    steps(15);

    // Load coincident with the wrap tick goes straight to active.
    step_load(16'h8888, 4'b0000);
    set_exp(16'h8888, 4'b0000);
    steps(22);

    // Disable mid-frame, load while off, re-enable.
    enable = 1'b0;
    step_off("dis");
    step_off("dis");
    digits_in = 16'h0009;
    dp_in     = 4'b0000;
    load      = 1'b1;
    step_off("dis_load");
    load      = 1'b0;
    step_off("dis");
    enable = 1'b1;
    k = 0;
    set_exp(16'h0009, 4'b0000);
    steps(10);

    // Asynchronous reset while digit 2 is driven.
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    #2;
    rst_n = 1'b1;
    k = 0;
    set_exp(16'h0000, 4'b0000);
    steps(20);

    // Values exercising leading-zero handling.
    step_load(16'h0052, 4'b0000);
    steps(11);
    set_exp(16'h0052, 4'b0000);
    steps(16);
    step_load(16'h0000, 4'b0000);
    steps(15);
    set_exp(16'h0000, 4'b0000);
    steps(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout k=%0d", k);
    $fatal(1, "timeout");
  end

endmodule
